// File: rtl/fibo_pkg.sv
// Shared widths, FSM encoding and the Fibonacci step helper for the fibo_check stream checker.
package fibo_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED1  = 3'd1,
        ST_SEED2  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // Next term of the LED sequence wraps modulo 256, matching an 8-bit display.
    function automatic logic [DATA_W-1:0] fib_next(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/fibo_phase.sv
// Term-phase tracker: counts cycles within a term and strobes once mid-term so held values are sampled.
module fibo_phase #(
    parameter logic [19:0] DECIMATION = 20'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic change,
    output logic strobe
);

    localparam logic [19:0] LAST = DECIMATION - 20'd1;
    localparam logic [19:0] HALF = DECIMATION / 20'd2;

    logic [19:0] phase_q;
    logic [19:0] phase_d;

    always_comb begin
        phase_d = phase_q + 20'd1;
        if (change || phase_q == LAST) begin
            phase_d = 20'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 20'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Strobe comes from the current phase, so a change landing on it re-phases without losing it.
    assign strobe = (phase_q == HALF);

endmodule

// File: rtl/fibo_check.sv
// Checks an 8-bit Fibonacci LED stream, locking once terms follow a+b; err_cnt only with FIBO_CHECK_CNT_EN.
module fibo_check
    import fibo_pkg::*;
#(
    parameter logic [19:0] DECIMATION = 20'd1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    output logic              locked,
    output logic              update,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              update_q, update_d;
    logic              err_q, err_d;
    logic              change;
    logic              strobe;
    logic              match;
    logic              checking;

    assign change   = (in != in_q);
    assign match    = (in_q == fib_next(a_q, b_q));
    assign checking = (state_q == ST_CHECK) || (state_q == ST_LOCKED);

    fibo_phase #(
        .DECIMATION(DECIMATION)
    ) u_phase (
        .clk   (clk),
        .reset (reset),
        .change(change),
        .strobe(strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            in_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_q     <= in;
            a_q      <= a_d;
            b_q      <= b_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (change) begin
                    state_d = ST_SEED1;
                end
            end
            ST_SEED1: begin
                if (strobe) begin
                    a_d     = in_q;
                    state_d = ST_SEED2;
                end
            end
            ST_SEED2: begin
                if (strobe) begin
                    b_d     = in_q;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK, ST_LOCKED: begin
                if (strobe) begin
                    if (match) begin
                        a_d     = b_q;
                        b_d     = in_q;
                        state_d = ST_LOCKED;
                    end else begin
                        // Resync: the failing term becomes the first seed.
                        a_d     = in_q;
                        state_d = ST_SEED2;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        update_d = strobe && checking && match;
        err_d    = strobe && checking && !match;
    end

    assign locked = (state_q == ST_LOCKED);
    assign update = update_q;
    assign err    = err_q;

`ifdef FIBO_CHECK_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fibo_check.sv
// Scoreboard bench for fibo_check: terms queue their expected pulse, a monitor checks each pulse in order.
module tb_fibo_check;

    localparam int DEC = 20;
    localparam int W   = 19;

    logic        clk;
    logic        reset;
    logic [7:0]  in;
    logic        locked;
    logic        update;
    logic        err;
    logic [15:0] err_cnt;

    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_cnt;
    int           checks;
    int           failures;

    fibo_check #(
        .DECIMATION(20'd20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .locked (locked),
        .update (update),
        .err    (err),
        .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 no output, 1 passing term, 2 failing term
    task automatic drive_term(input logic [7:0] v, input int kind);
        if (kind == 1) begin
            exp_q.push_back({1'b1, 1'b0, 1'b1, exp_cnt});
        end else if (kind == 2) begin
`ifdef FIBO_CHECK_CNT_EN
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            exp_q.push_back({1'b0, 1'b1, 1'b0, exp_cnt});
        end
        @(negedge clk);
        in = v;
        repeat (DEC - 1) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {15'd0, locked, update, err}, '0);
        check(name, {3'd0, err_cnt}, '0);
    endtask

    always @(negedge clk) begin
        if (!reset && (update || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {update, err, locked, err_cnt}, '0);
            end else begin
                check("pulse", {update, err, locked, err_cnt}, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;
        in       = 8'd0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b0;

        // Fresh start: seeds 1,1 then four passing terms.
        drive_term(8'd0, 0);
        drive_term(8'd1, 0);
        drive_term(8'd1, 0);
        check("unlocked_after_seeds", {18'd0, locked}, '0);
        drive_term(8'd2, 1);
        drive_term(8'd3, 1);
        drive_term(8'd5, 1);
        drive_term(8'd8, 1);
        check("locked_after_8", {18'd0, locked}, 19'd1);

        // 14 instead of 13 fails, then 14 seeds a new run 14,22,36.
        drive_term(8'd14, 2);
        drive_term(8'd22, 0);
        check("unlocked_during_resync", {18'd0, locked}, '0);
        drive_term(8'd36, 1);
        check("relocked_on_36", {18'd0, locked}, 19'd1);

        // Reset while locked drops everything immediately.
        @(negedge clk);
        reset = 1'b1;
        in    = 8'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("outputs_in_reset_locked", {18'd0, locked}, '0);
            check("outputs_in_reset_pulses", {17'd0, update, err}, '0);
            check("outputs_in_reset_cnt", {3'd0, err_cnt}, '0);
            @(negedge clk);
        end
        reset   = 1'b0;
        exp_cnt = 16'd0;

        // 8-bit wrap: 144+233 = 377 -> 121.
        drive_term(8'd34, 0);
        drive_term(8'd55, 0);
        check("unlocked_after_reset_seeds", {18'd0, locked}, '0);
        drive_term(8'd89, 1);
        drive_term(8'd144, 1);
        drive_term(8'd233, 1);
        drive_term(8'd121, 1);
        check("locked_after_wrap", {18'd0, locked}, 19'd1);

        // Constant 7: fail, reseed b=7, fail (7 != 14), ...
        drive_term(8'd7, 2);
        drive_term(8'd7, 0);
        drive_term(8'd7, 2);
        drive_term(8'd7, 0);
        drive_term(8'd7, 2);

`ifdef FIBO_CHECK_CNT_EN
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.err_cnt_q;
        exp_cnt = 16'hFFFD;
`endif
        // Three more mismatches to hit and hold saturation.
        drive_term(8'd7, 0);
        drive_term(8'd7, 2);
        drive_term(8'd7, 0);
        drive_term(8'd7, 2);
        drive_term(8'd7, 0);
        drive_term(8'd7, 2);

        repeat (DEC) @(negedge clk);
        check("drain_queue", W'(exp_q.size()), '0);
`ifdef FIBO_CHECK_CNT_EN
        check("final_err_cnt", {3'd0, err_cnt}, {3'd0, 16'hFFFF});
`else
        check("final_err_cnt", {3'd0, err_cnt}, '0);
`endif
        check("final_unlocked", {18'd0, locked}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
